// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD sequencer.
// Holds the FSM state encoding, o_lcd bit positions and the power-on init ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWR,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_e;

    localparam int LCD_ON_BIT = 31;
    localparam int LCD_EN_BIT = 10;
    localparam int LCD_RS_BIT = 9;
    localparam int LCD_RW_BIT = 8;

    // 8-bit bus / 2 lines, display on, clear, entry mode increment
    localparam int INIT_LEN = 4;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter used for every LCD timing phase.
// Holds at zero until reloaded; zero flags the last cycle of a phase.
module lcd_delay_counter #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - WIDTH'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// HD44780 sequencer: power-on init, then one byte per valid/ready handshake,
// generating RS/EN timing and the execution wait for each write.
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 3,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 1,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 82000,
    parameter int T_PWR   = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    output logic        o_init_done,
    output logic        o_busy,
    output logic [31:0] o_lcd
);

    localparam int T_MAX = max_of(max_of(max_of(T_SETUP, T_EN), max_of(T_HOLD, T_EXEC)),
                                  max_of(T_LONG, T_PWR));
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int IDX_W = $clog2(INIT_LEN);

    localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] LD_EN    = TW'(T_EN - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);
    localparam logic [TW-1:0] LD_EXEC  = TW'(T_EXEC - 1);
    localparam logic [TW-1:0] LD_LONG  = TW'(T_LONG - 1);
    localparam logic [TW-1:0] LD_PWR   = TW'(T_PWR - 1);

    state_e             state;
    state_e             next_state;
    logic               timer_load;
    logic [TW-1:0]      timer_load_value;
    logic               timer_zero;
    logic               accept;
    logic               rom_load;
    logic               set_done;
    logic [IDX_W-1:0]   rom_idx_next;
    logic [IDX_W-1:0]   init_idx;
    logic               init_done_q;
    logic               on_q;
    logic               rs_q;
    logic [7:0]         data_q;
    logic               is_long;

    // Clear and home (commands 0x01..0x03) need the long execution wait
    assign is_long = !rs_q && (data_q[7:2] == 6'd0);

    lcd_delay_counter #(
        .WIDTH       (TW),
        .RESET_VALUE (LD_PWR)
    ) u_timer (
        .clk        (i_clk),
        .rst_n      (i_rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_PWR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        timer_load       = 1'b0;
        timer_load_value = '0;
        accept           = 1'b0;
        rom_load         = 1'b0;
        rom_idx_next     = init_idx;
        set_done         = 1'b0;
        case (state)
            S_PWR: begin
                if (timer_zero) begin
                    next_state       = S_SETUP;
                    timer_load       = 1'b1;
                    timer_load_value = LD_SETUP;
                    rom_load         = 1'b1;
                    rom_idx_next     = '0;
                end
            end
            S_SETUP: begin
                if (timer_zero) begin
                    next_state       = S_PULSE;
                    timer_load       = 1'b1;
                    timer_load_value = LD_EN;
                end
            end
            S_PULSE: begin
                if (timer_zero) begin
                    next_state       = S_HOLD;
                    timer_load       = 1'b1;
                    timer_load_value = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (timer_zero) begin
                    next_state       = S_WAIT;
                    timer_load       = 1'b1;
                    timer_load_value = is_long ? LD_LONG : LD_EXEC;
                end
            end
            S_WAIT: begin
                if (timer_zero) begin
                    if (init_done_q) begin
                        next_state = S_IDLE;
                    end else if (init_idx != IDX_W'(INIT_LEN - 1)) begin
                        next_state       = S_SETUP;
                        timer_load       = 1'b1;
                        timer_load_value = LD_SETUP;
                        rom_load         = 1'b1;
                        rom_idx_next     = init_idx + IDX_W'(1);
                    end else begin
                        next_state = S_IDLE;
                        set_done   = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (i_valid) begin
                    next_state       = S_SETUP;
                    timer_load       = 1'b1;
                    timer_load_value = LD_SETUP;
                    accept           = 1'b1;
                end
            end
            default: begin
                next_state = S_PWR;
            end
        endcase
    end

    // RS/DATA stay registered until the next ROM load or user accept
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            on_q        <= 1'b0;
            init_done_q <= 1'b0;
            init_idx    <= '0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            on_q <= 1'b1;
            if (set_done) begin
                init_done_q <= 1'b1;
            end
            if (rom_load) begin
                init_idx <= rom_idx_next;
                rs_q     <= 1'b0;
                data_q   <= INIT_ROM[rom_idx_next];
            end else if (accept) begin
                rs_q   <= i_rs;
                data_q <= i_data;
            end
        end
    end

    always_comb begin
        o_lcd             = '0;
        o_lcd[LCD_ON_BIT] = on_q;
        o_lcd[LCD_EN_BIT] = (state == S_PULSE);
        o_lcd[LCD_RS_BIT] = rs_q;
        o_lcd[LCD_RW_BIT] = 1'b0;
        o_lcd[7:0]        = data_q;
    end

    assign o_ready     = (state == S_IDLE);
    assign o_busy      = ~o_ready;
    assign o_init_done = init_done_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Self-checking bench for lcd_seq_ctrl: directed init/handshake/reset scenarios
// plus randomized writes, all checked every cycle against a transfer-level model.
module tb_lcd_seq_ctrl;

    localparam int TS    = 1;
    localparam int TEN   = 2;
    localparam int THOLD = 1;
    localparam int TEXEC = 4;
    localparam int TLONG = 10;
    localparam int TPWR  = 8;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        rs;
    logic [7:0]  data;
    logic        ready;
    logic        init_done;
    logic        busy;
    logic [31:0] lcd;

    int n_cmp  = 0;
    int n_fail = 0;

    lcd_seq_ctrl #(
        .T_SETUP (TS),
        .T_EN    (TEN),
        .T_HOLD  (THOLD),
        .T_EXEC  (TEXEC),
        .T_LONG  (TLONG),
        .T_PWR   (TPWR)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_rs        (rs),
        .i_data      (data),
        .o_init_done (init_done),
        .o_busy      (busy),
        .o_lcd       (lcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer-level model: a write is just an offset into a fixed-length window
    typedef struct {
        int         pwr_left;
        bit         xfer;
        int         off;
        int         len;
        bit         rs;
        logic [7:0] data;
        int         init_idx;
        bit         init_done;
        bit         pwr_on;
    } model_t;

    model_t m;

    function automatic logic [7:0] rom_byte(input int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic model_t model_reset();
        model_t s;
        s.pwr_left  = TPWR;
        s.xfer      = 1'b0;
        s.off       = 0;
        s.len       = 0;
        s.rs        = 1'b0;
        s.data      = 8'h00;
        s.init_idx  = 0;
        s.init_done = 1'b0;
        s.pwr_on    = 1'b0;
        return s;
    endfunction

    function automatic model_t model_start(input model_t s, input bit r, input logic [7:0] d);
        model_t n = s;
        n.xfer = 1'b1;
        n.off  = 0;
        n.rs   = r;
        n.data = d;
        n.len  = TS + TEN + THOLD + ((!r && d < 8'd4) ? TLONG : TEXEC);
        return n;
    endfunction

    function automatic model_t model_step(input model_t s, input bit v, input bit r, input logic [7:0] d);
        model_t n = s;
        n.pwr_on = 1'b1;
        if (s.pwr_left > 0) begin
            n.pwr_left = s.pwr_left - 1;
            if (n.pwr_left == 0) n = model_start(n, 1'b0, rom_byte(0));
        end else if (s.xfer) begin
            n.off = s.off + 1;
            if (n.off == s.len) begin
                n.xfer = 1'b0;
                if (!s.init_done) begin
                    if (s.init_idx < 3) begin
                        n.init_idx = s.init_idx + 1;
                        n = model_start(n, 1'b0, rom_byte(n.init_idx));
                    end else begin
                        n.init_done = 1'b1;
                    end
                end
            end
        end else if (v) begin
            n = model_start(n, r, d);
        end
        return n;
    endfunction

    function automatic bit model_ready(input model_t s);
        return (s.pwr_left == 0) && !s.xfer && s.pwr_on;
    endfunction

    function automatic logic [31:0] model_lcd(input model_t s);
        logic [31:0] e = '0;
        e[31]  = s.pwr_on;
        e[10]  = s.xfer && (s.off >= TS) && (s.off < TS + TEN);
        e[9]   = s.rs;
        e[7:0] = s.data;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, valid, rs, data);
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            check_output("model_lcd", lcd, model_lcd(m));
            check_output("model_ready", 32'(ready), 32'(model_ready(m)));
            check_output("model_busy", 32'(busy), 32'(!model_ready(m)));
            check_output("model_init_done", 32'(init_done), 32'(m.init_done));
        end
    end

    // EN rising-edge log of {RS, DATA}
    logic [8:0] pulse_log [$];
    logic       en_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n && lcd[10] && !en_prev) pulse_log.push_back({lcd[9], lcd[7:0]});
        en_prev <= lcd[10];
    end

    task automatic wait_ready(input string name, input int bound);
        int k = 0;
        while (!ready && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (!ready) report_timeout(name);
    endtask

    // Releases reset and follows the whole init sequence up to the first o_ready
    task automatic observe_init(input bit hold_valid, input logic [7:0] vdata);
        logic [7:0] pd [4];
        bit         prs [4];
        int         gaps [4];
        int         n = 0, npulse = 0, zeros = 0, first_en = -1, ready_at = -1;
        bit         prev_en = 1'b0, early_en = 1'b0, done_before = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pd[i] = 8'h00; prs[i] = 1'b1; gaps[i] = -1;
        end
        valid = hold_valid;
        rs    = 1'b1;
        data  = vdata;
        @(negedge clk);
        rst_n = 1'b1;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (n == 1) check_output("on_after_release", 32'(lcd[31]), 32'd1);
            if (lcd[10] && n <= TPWR) early_en = 1'b1;
            if (lcd[10] && !prev_en) begin
                if (npulse == 0) first_en = n;
                if (npulse < 4) begin
                    pd[npulse] = lcd[7:0]; prs[npulse] = lcd[9]; gaps[npulse] = zeros;
                end
                npulse++;
            end
            zeros   = lcd[10] ? 0 : zeros + 1;
            prev_en = lcd[10];
            if (ready) begin
                ready_at = n;
                break;
            end
            done_before = init_done;
        end
        if (ready_at < 0) report_timeout("init_ready");
        check_output("no_en_during_pwr", 32'(early_en), 32'd0);
        check_output("first_en_cycle", 32'(first_en), 32'd9);
        check_output("init_pulse_count", 32'(npulse), 32'd4);
        check_output("init_byte0", 32'(pd[0]), 32'h38);
        check_output("init_byte1", 32'(pd[1]), 32'h0C);
        check_output("init_byte2", 32'(pd[2]), 32'h01);
        check_output("init_byte3", 32'(pd[3]), 32'h06);
        check_output("init_rs", 32'({prs[0], prs[1], prs[2], prs[3]}), 32'd0);
        check_output("gap_after_38", 32'(gaps[1]), 32'd6);
        check_output("gap_after_0C", 32'(gaps[2]), 32'd6);
        check_output("gap_after_01", 32'(gaps[3]), 32'd12);
        check_output("ready_cycle", 32'(ready_at), 32'd46);
        check_output("init_done_late", 32'(done_before), 32'd0);
        check_output("init_done_set", 32'(init_done), 32'd1);
        if (hold_valid) begin
            @(negedge clk);
            check_output("late_accept_ready", 32'(ready), 32'd0);
            check_output("late_accept_data", 32'(lcd[7:0]), 32'(vdata));
            valid = 1'b0;
            wait_ready("late_accept_done", 50);
        end
    endtask

    // One write from IDLE; reports busy length, EN-high cycles and RS/DATA stability
    task automatic apply_stimulus(input bit wrs, input logic [7:0] wd,
                                  output int busy_cnt, output int en_cnt, output bit stable);
        valid = 1'b1;
        rs    = wrs;
        data  = wd;
        @(negedge clk);
        valid    = 1'b0;
        busy_cnt = 0;
        en_cnt   = 0;
        stable   = 1'b1;
        while (!ready && busy_cnt < 100) begin
            busy_cnt++;
            if (lcd[10]) en_cnt++;
            if (lcd[9] !== wrs || lcd[7:0] !== wd) stable = 1'b0;
            @(negedge clk);
        end
        if (!ready) report_timeout("write_done");
    endtask

    initial begin
        int  bc, ec;
        bit  st;
        int  k;
        rst_n = 1'b0;
        valid = 1'b0;
        rs    = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check_output("reset_lcd", lcd, 32'h0);
        check_output("reset_ready", 32'(ready), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd1);
        check_output("reset_init_done", 32'(init_done), 32'd0);
        cmp_on = 1'b1;

        $display("[TB] test 1: init sequence");
        observe_init(1'b0, 8'h00);

        $display("[TB] test 2: data write 0x41");
        apply_stimulus(1'b1, 8'h41, bc, ec, st);
        check_output("w41_busy", 32'(bc), 32'd8);
        check_output("w41_en", 32'(ec), 32'd2);
        check_output("w41_stable", 32'(st), 32'd1);
        check_output("w41_hold_after", 32'(lcd[9:0]), 32'h241);

        $display("[TB] test 3: command timing");
        apply_stimulus(1'b0, 8'h01, bc, ec, st);
        check_output("c01_busy", 32'(bc), 32'd14);
        apply_stimulus(1'b0, 8'h80, bc, ec, st);
        check_output("c80_busy", 32'(bc), 32'd8);
        apply_stimulus(1'b0, 8'h03, bc, ec, st);
        check_output("c03_busy", 32'(bc), 32'd14);
        apply_stimulus(1'b0, 8'h04, bc, ec, st);
        check_output("c04_busy", 32'(bc), 32'd8);
        apply_stimulus(1'b1, 8'h01, bc, ec, st);
        check_output("d01_busy", 32'(bc), 32'd8);

        $display("[TB] test 4: valid held across completion");
        pulse_log.delete();
        valid = 1'b1;
        rs    = 1'b1;
        data  = 8'h48;
        @(negedge clk);
        data = 8'h49;
        wait_ready("held_first", 50);
        @(negedge clk);
        check_output("held_second_accept", 32'(ready), 32'd0);
        check_output("held_second_data", 32'(lcd[7:0]), 32'h49);
        valid = 1'b0;
        wait_ready("held_second", 50);
        repeat (6) @(negedge clk);
        check_output("held_pulse_count", 32'(pulse_log.size()), 32'd2);
        if (pulse_log.size() == 2) begin
            check_output("held_pulse0", 32'(pulse_log[0]), 32'h148);
            check_output("held_pulse1", 32'(pulse_log[1]), 32'h149);
        end

        $display("[TB] test 5: valid during init");
        rst_n = 1'b0;
        @(negedge clk);
        observe_init(1'b1, 8'hAA);

        $display("[TB] test 6: reset mid pulse");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!lcd[10] && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!lcd[10]) report_timeout("find_pulse");
        #1 rst_n = 1'b0;
        #1;
        check_output("async_lcd_zero", lcd, 32'h0);
        check_output("async_busy", 32'(busy), 32'd1);
        @(negedge clk);
        observe_init(1'b0, 8'h00);

        $display("[TB] random phase");
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) != 0);
            rs    = 1'($urandom_range(0, 1));
            data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        end
        valid = 1'b0;
        @(negedge clk);
        wait_ready("random_drain", 50);
        repeat (2) @(negedge clk);
        cmp_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
